// File: rtl/nexys_starship_pkg.sv
// Shared constants for the starship room/breakdown blocks: room indices,
// one-hot FSM encodings and the breakdown LFSR recurrence.
package nexys_starship_pkg;

    localparam logic [1:0] ROOM_LEFT   = 2'd0;
    localparam logic [1:0] ROOM_RIGHT  = 2'd1;
    localparam logic [1:0] ROOM_TOP    = 2'd2;
    localparam logic [1:0] ROOM_BOTTOM = 2'd3;

    localparam logic [2:0] IDLE = 3'b001;
    localparam logic [2:0] RUN  = 3'b010;
    localparam logic [2:0] PICK = 3'b100;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // 29 bits so the 300M-cycle default interval is representable.
    localparam int TIMER_W = 29;

    typedef enum logic [2:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_PICK = PICK
    } bd_state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] nxt;
        if (v == 16'h0000) begin
            nxt = 16'h0001;
        end else begin
            nxt = {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
        end
        return nxt;
    endfunction

    function automatic logic [3:0] room_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            ROOM_LEFT:   oh = 4'b0001;
            ROOM_RIGHT:  oh = 4'b0010;
            ROOM_TOP:    oh = 4'b0100;
            ROOM_BOTTOM: oh = 4'b1000;
            default:     oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/nexys_starship_breakdown_if.sv
// Game-control and room-strobe bundle between the game controller (master)
// and the breakdown event source (slave).
interface nexys_starship_breakdown_if;

    logic       play_flag;
    logic       gameover_ctrl;
    logic [3:0] broken_status;
    logic [3:0] break_pulse;
    logic [3:0] random_hex;
    logic       q_Idle;
    logic       q_Run;
    logic       q_Pick;

    modport master (
        output play_flag, gameover_ctrl, broken_status,
        input  break_pulse, random_hex, q_Idle, q_Run, q_Pick
    );

    modport slave (
        input  play_flag, gameover_ctrl, broken_status,
        output break_pulse, random_hex, q_Idle, q_Run, q_Pick
    );

endinterface

// File: rtl/nexys_starship_breakdown_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the breakdown randomness source;
// steps every cycle and recovers from the all-zero lockup state.
module starship_lfsr16
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/nexys_starship_breakdown.sv
// Breakdown event source: after a programmable interval fires a one-cycle strobe
// to a random working room with a repair combo. Ramping enabled by BREAKDOWN_RAMP_EN.
//
// state | meaning
// IDLE  | no game; timer and interval held at INIT_INTERVAL
// RUN   | counting the timer down to zero
// PICK  | one cycle: choose room, fire, reload timer
module nexys_starship_breakdown
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0]        LFSR_SEED     = 16'hACE1,
    parameter logic [TIMER_W-1:0] INIT_INTERVAL = 29'd300_000_000,
    parameter logic [TIMER_W-1:0] MIN_INTERVAL  = 29'd50_000_000,
    parameter logic [TIMER_W-1:0] STEP          = 29'd10_000_000
) (
    input  logic                     Clk,
    input  logic                     Reset,
    nexys_starship_breakdown_if.slave bif
);

    bd_state_e          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TIMER_W-1:0] interval_q, interval_d;
    logic [TIMER_W-1:0] next_interval;
    logic [3:0]         pulse_q, pulse_d;
    logic [3:0]         hex_q, hex_d;

    logic [15:0] lfsr;
    logic [1:0]  cand;
    logic [1:0]  probe;
    logic [1:0]  pick_idx;
    logic        found;
    logic [3:0]  combo;
    logic        unused_lfsr_bits;

    starship_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .lfsr  (lfsr)
    );

    assign cand             = lfsr[1:0];
    assign combo            = (lfsr[7:4] == 4'h0) ? 4'hA : lfsr[7:4];
    assign unused_lfsr_bits = ^{lfsr[15:8], lfsr[3:2]};

    // Walk rooms starting at the candidate; last hit in the reversed loop is the first working room.
    always_comb begin
        found    = 1'b0;
        pick_idx = cand;
        probe    = cand;
        for (int j = 3; j >= 0; j--) begin
            probe = cand + 2'(j);
            if (!bif.broken_status[probe]) begin
                found    = 1'b1;
                pick_idx = probe;
            end
        end
    end

`ifdef BREAKDOWN_RAMP_EN
    assign next_interval = ({1'b0, interval_q} < ({1'b0, STEP} + {1'b0, MIN_INTERVAL}))
                           ? MIN_INTERVAL : interval_q - STEP;
`else
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = ^{STEP, MIN_INTERVAL};
    assign next_interval   = interval_q;
`endif

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        interval_d = interval_q;
        pulse_d    = 4'b0000;
        hex_d      = hex_q;
        if (bif.gameover_ctrl) begin
            state_d    = S_IDLE;
            timer_d    = INIT_INTERVAL;
            interval_d = INIT_INTERVAL;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timer_d    = INIT_INTERVAL;
                    interval_d = INIT_INTERVAL;
                    if (bif.play_flag) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (timer_q == '0) begin
                        state_d = S_PICK;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                S_PICK: begin
                    state_d = S_RUN;
                    if (found) begin
                        pulse_d    = room_onehot(pick_idx);
                        hex_d      = combo;
                        interval_d = next_interval;
                        timer_d    = next_interval;
                    end else begin
                        timer_d = interval_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            timer_q    <= INIT_INTERVAL;
            interval_q <= INIT_INTERVAL;
            pulse_q    <= 4'b0000;
            hex_q      <= 4'h0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            interval_q <= interval_d;
            pulse_q    <= pulse_d;
            hex_q      <= hex_d;
        end
    end

    assign bif.break_pulse = pulse_q;
    assign bif.random_hex  = hex_q;
    assign bif.q_Idle      = (state_q == S_IDLE);
    assign bif.q_Run       = (state_q == S_RUN);
    assign bif.q_Pick      = (state_q == S_PICK);

endmodule

// File: tb/tb_nexys_starship_breakdown.sv
// Randomised and directed bench for nexys_starship_breakdown against a
// fire-schedule reference model (INIT=10, MIN=4, STEP=3).
module tb_nexys_starship_breakdown;
    import nexys_starship_pkg::*;

    localparam int          INIT = 10;
    localparam int          MINI = 4;
    localparam int          STPV = 3;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef BREAKDOWN_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;

    nexys_starship_breakdown_if bif();

    nexys_starship_breakdown #(
        .LFSR_SEED     (SEED),
        .INIT_INTERVAL (TIMER_W'(INIT)),
        .MIN_INTERVAL  (TIMER_W'(MINI)),
        .STEP          (TIMER_W'(STPV))
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bif   (bif.slave)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Reference model: tracks when the next PICK is due rather than a timer.
    logic [15:0] m_lfsr      = SEED;
    bit          m_active    = 1'b0;
    logic [3:0]  m_pulse     = 4'h0;
    logic [3:0]  m_hex       = 4'h0;
    int          m_interval  = INIT;
    int          m_pick_edge = -100;
    int          m_room;
    int          m_c;

    function automatic logic [15:0] model_lfsr_next(input logic [15:0] v);
        if (v == 16'h0000) return 16'h0001;
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [2:0] exp_state();
        if (!m_active) return 3'b001;
        if (cyc == m_pick_edge) return 3'b100;
        return 3'b010;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_lfsr      = SEED;
            m_active    = 1'b0;
            m_pulse     = 4'h0;
            m_hex       = 4'h0;
            m_interval  = INIT;
            m_pick_edge = -100;
            cyc         = 0;
        end else begin
            cyc++;
            m_pulse = 4'h0;
            if (bif.gameover_ctrl) begin
                m_active   = 1'b0;
                m_interval = INIT;
            end else if (!m_active) begin
                m_interval = INIT;
                if (bif.play_flag) begin
                    m_active    = 1'b1;
                    m_pick_edge = cyc + INIT + 1;
                end
            end else if (cyc == m_pick_edge + 1) begin
                m_c    = int'(m_lfsr[1:0]);
                m_room = -1;
                for (int j = 0; j < 4; j++)
                    if (m_room < 0 && !bif.broken_status[(m_c + j) % 4]) m_room = (m_c + j) % 4;
                if (m_room >= 0) begin
                    m_pulse = 4'(1 << m_room);
                    m_hex   = (m_lfsr[7:4] == 4'h0) ? 4'hA : m_lfsr[7:4];
                    if (RAMP) m_interval = (m_interval - STPV < MINI) ? MINI : m_interval - STPV;
                end
                m_pick_edge = cyc + m_interval + 1;
            end
            m_lfsr = model_lfsr_next(m_lfsr);
        end
    end

    bit chk_en = 1'b0;
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("pulse", 32'(bif.break_pulse), 32'(m_pulse));
            chk("hex", 32'(bif.random_hex), 32'(m_hex));
            chk("state", 32'({bif.q_Pick, bif.q_Run, bif.q_Idle}), 32'(exp_state()));
        end
    end

    task automatic wait_fire(output int t);
        t = -1;
        for (int i = 0; i < 200 && t < 0; i++) begin
            @(negedge Clk);
            if (bif.break_pulse != 4'h0) begin
                t = cyc;
                chk("fire_onehot", 32'($countones(bif.break_pulse)), 32'd1);
                chk("hex_nonzero", 32'(bif.random_hex != 4'h0), 32'd1);
            end
        end
        if (t < 0) chk("fire_seen", 32'(bif.break_pulse != 4'h0), 32'd1);
    endtask

    task automatic wait_pick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge Clk);
            if (m_active && cyc == m_pick_edge) ok = 1'b1;
        end
        if (!ok) chk("pick_seen", 32'(bif.q_Pick), 32'd1);
    endtask

    int         f[4];
    int         exp_gap[3];
    int         e, t, p0, c;
    bit         ok, seen_left;
    logic [3:0] exp_pulse, mh;

    initial begin
        bif.play_flag     = 1'b0;
        bif.gameover_ctrl = 1'b0;
        bif.broken_status = 4'h0;
        Reset             = 1'b1;
        repeat (3) @(negedge Clk);
        Reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge Clk);
        chk("rst_pulse", 32'(bif.break_pulse), 32'd0);
        chk("rst_hex", 32'(bif.random_hex), 32'd0);
        chk("rst_idle", 32'(bif.q_Idle), 32'd1);

        // basic fire and ramp gaps
        bif.play_flag = 1'b1;
        @(posedge Clk); #1;
        e = cyc;
        for (int k = 0; k < 4; k++) wait_fire(f[k]);
        chk("first_fire", 32'(f[0] - e), 32'd12);
        if (RAMP) begin exp_gap[0] = 9;  exp_gap[1] = 6;  exp_gap[2] = 6;  end
        else      begin exp_gap[0] = 12; exp_gap[1] = 12; exp_gap[2] = 12; end
        for (int k = 0; k < 3; k++) chk("gap", 32'(f[k+1] - f[k]), 32'(exp_gap[k]));

        // game over landing on PICK
        wait_pick(ok);
        bif.gameover_ctrl = 1'b1;
        @(negedge Clk);
        chk("go_pulse", 32'(bif.break_pulse), 32'd0);
        chk("go_idle", 32'(bif.q_Idle), 32'd1);
        bif.gameover_ctrl = 1'b0;
        @(posedge Clk); #1;
        e = cyc;
        wait_fire(t);
        chk("go_reload", 32'(t - e), 32'd12);

        // skip rule: candidate and its successor broken
        seen_left = 1'b0;
        for (int k = 0; k < 40 && !seen_left; k++) begin
            wait_pick(ok);
            c = int'(m_lfsr[1:0]);
            bif.broken_status = 4'((1 << c) | (1 << ((c + 1) % 4)));
            exp_pulse = 4'(1 << ((c + 2) % 4));
            if (c == 0) seen_left = 1'b1;
            @(negedge Clk);
            chk(c == 0 ? "skip_left" : "skip", 32'(bif.break_pulse), 32'(exp_pulse));
            bif.broken_status = 4'h0;
        end

        // all rooms broken from a fresh interval
        bif.gameover_ctrl = 1'b1;
        @(negedge Clk);
        bif.gameover_ctrl = 1'b0;
        wait_pick(ok);
        bif.broken_status = 4'hF;
        mh = m_hex;
        p0 = cyc;
        @(negedge Clk);
        chk("allbrk_pulse", 32'(bif.break_pulse), 32'd0);
        chk("allbrk_hex", 32'(bif.random_hex), 32'(mh));
        wait_pick(ok);
        chk("allbrk_gap", 32'(cyc - p0), 32'd12);
        bif.broken_status = 4'h0;

        // asynchronous reset in the middle of RUN
        repeat (5) @(negedge Clk);
        @(posedge Clk); #3;
        Reset = 1'b1;
        #1;
        chk("arst_pulse", 32'(bif.break_pulse), 32'd0);
        chk("arst_hex", 32'(bif.random_hex), 32'd0);
        chk("arst_idle", 32'(bif.q_Idle), 32'd1);
        chk("arst_run", 32'(bif.q_Run), 32'd0);
        bif.play_flag = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (20) @(negedge Clk);
        chk("idle_hold", 32'(bif.q_Idle), 32'd1);

        // randomised play
        for (int k = 0; k < 3000; k++) begin
            @(negedge Clk);
            bif.broken_status = 4'($urandom);
            bif.gameover_ctrl = ($urandom_range(0, 59) == 0);
            bif.play_flag     = ($urandom_range(0, 9) != 0);
        end
        @(negedge Clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
